wired_cdb_arbiter: RTL and testbench

- Sits downstream of the int/mdu/lsu issue-queue + FU blocks and arbitrates their results onto the two CDB broadcast lanes.
- Each source owns a 1-entry skid buffer, so FU-side ready is a registered signal.
- Selection is fixed priority: lower source index wins (LSU > MDU > ALU).
- Up to two results per cycle are granted, and the CDB output is registered.

---
 rtl/wired_cdb_arbiter_pkg.sv | 24 ++
 rtl/wired_cdb_skid.sv | 43 ++++
 rtl/wired_cdb_arbiter.sv | 78 +++++++
 tb/tb_wired_cdb_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wired_cdb_arbiter_pkg.sv
// Shared types and source indices for the CDB result arbiter.
// The index constants give the fixed priority order, so index 0 is the highest priority.
package wired_cdb_arbiter_pkg;

    localparam int ROB_ID_W   = 6;
    localparam int DATA_W     = 32;
    localparam int EXC_CODE_W = 5;

    typedef struct packed {
        logic [ROB_ID_W-1:0]   rob_id;
        logic [DATA_W-1:0]     wdata;
        logic                  exc_valid;
        logic [EXC_CODE_W-1:0] exc_code;
    } pipeline_cdb_t;

    localparam int CDB_SRC_LSU0 = 0;
    localparam int CDB_SRC_LSU1 = 1;
    localparam int CDB_SRC_MDU0 = 2;
    localparam int CDB_SRC_MDU1 = 3;
    localparam int CDB_SRC_ALU0 = 4;
    localparam int CDB_SRC_ALU1 = 5;
    localparam int CDB_NUM_SRC  = 6;

endpackage

// File: rtl/wired_cdb_skid.sv
// One-entry skid buffer in front of the CDB arbiter for a single result source.
// A buffered entry is always presented before the live input, which keeps per-source order.
module wired_cdb_skid
    import wired_cdb_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          in_valid,
    output logic          in_ready,
    input  pipeline_cdb_t in_payload,
    output logic          out_valid,
    output pipeline_cdb_t out_payload,
    input  logic          grant_i
);

    logic          full_q;
    pipeline_cdb_t buf_q;
    logic          fire;

    assign in_ready    = ~full_q;
    assign fire        = in_valid & ~full_q;
    assign out_valid   = full_q | in_valid;
    assign out_payload = full_q ? buf_q : in_payload;

    // Ready is registered, so a full buffer never accepts; draining it frees the slot for next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            full_q <= 1'b0;
        end else if (grant_i) begin
            full_q <= full_q & fire;
        end else if (fire) begin
            full_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fire && !grant_i) begin
            buf_q <= in_payload;
        end
    end

endmodule

// File: rtl/wired_cdb_arbiter.sv
// Fixed-priority arbiter placing up to two FU results per cycle onto the two CDB lanes.
// Lower source index wins; lane 0 always carries the higher-priority winner.
module wired_cdb_arbiter
    import wired_cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC   = CDB_NUM_SRC,
    parameter int CDB_LANES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  pipeline_cdb_t [NUM_SRC-1:0]   fu_payload_i,
    input  logic [NUM_SRC-1:0]            fu_valid_i,
    output logic [NUM_SRC-1:0]            fu_ready_o,
    output pipeline_cdb_t [CDB_LANES-1:0] cdb_payload_o,
    output logic [CDB_LANES-1:0]          cdb_valid_o,
    input  logic                          flush_i
);

    if (CDB_LANES != 2) begin : g_lane_check
        $error("wired_cdb_arbiter supports exactly two CDB lanes");
    end

    function automatic logic [NUM_SRC-1:0] lowest_onehot(input logic [NUM_SRC-1:0] vec);
        return vec & (-vec);
    endfunction

    logic [NUM_SRC-1:0]          cand_valid;
    pipeline_cdb_t [NUM_SRC-1:0] cand_data;
    logic [NUM_SRC-1:0]          grant_oh0;
    logic [NUM_SRC-1:0]          grant_oh1;
    logic [NUM_SRC-1:0]          grant;
    pipeline_cdb_t               lane0_data;
    pipeline_cdb_t               lane1_data;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_skid
        wired_cdb_skid u_skid (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush_i     (flush_i),
            .in_valid    (fu_valid_i[s]),
            .in_ready    (fu_ready_o[s]),
            .in_payload  (fu_payload_i[s]),
            .out_valid   (cand_valid[s]),
            .out_payload (cand_data[s]),
            .grant_i     (grant[s])
        );
    end

    // Grant stage: second lane takes the lowest candidate left after removing the first winner.
    always_comb begin
        grant_oh0  = lowest_onehot(cand_valid);
        grant_oh1  = lowest_onehot(cand_valid & ~grant_oh0);
        lane0_data = '0;
        lane1_data = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (grant_oh0[s]) lane0_data = cand_data[s];
            if (grant_oh1[s]) lane1_data = cand_data[s];
        end
    end

    assign grant = grant_oh0 | grant_oh1;

    // Output stage: payload is held while a lane idles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cdb_valid_o   <= '0;
            cdb_payload_o <= '0;
        end else if (flush_i) begin
            cdb_valid_o   <= '0;
        end else begin
            cdb_valid_o[0] <= |grant_oh0;
            cdb_valid_o[1] <= |grant_oh1;
            if (|grant_oh0) cdb_payload_o[0] <= lane0_data;
            if (|grant_oh1) cdb_payload_o[1] <= lane1_data;
        end
    end

endmodule

// File: tb/tb_wired_cdb_arbiter.sv
// Randomized and directed bench for wired_cdb_arbiter against a per-source queue model.
module tb_wired_cdb_arbiter;
    import wired_cdb_arbiter_pkg::*;

    localparam int NS = 6;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     flush = 1'b0;
    logic [NS-1:0]            fu_valid = '0;
    logic [NS-1:0]            fu_ready;
    pipeline_cdb_t [NS-1:0]   fu_payload = '0;
    pipeline_cdb_t [1:0]      cdb_payload;
    logic [1:0]               cdb_valid;

    always #5 clk = ~clk;

    wired_cdb_arbiter #(.NUM_SRC(NS), .CDB_LANES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fu_payload_i  (fu_payload),
        .fu_valid_i    (fu_valid),
        .fu_ready_o    (fu_ready),
        .cdb_payload_o (cdb_payload),
        .cdb_valid_o   (cdb_valid),
        .flush_i       (flush)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Model: each result sits in its source's queue until it wins one of the two lanes.
    pipeline_cdb_t src_q [NS][$];
    pipeline_cdb_t pend  [NS][$];
    logic [NS-1:0] acc = '0;
    logic [1:0]    exp_valid = '0;
    pipeline_cdb_t exp_pay [2];

    function automatic pipeline_cdb_t mk_item(input int rob);
        pipeline_cdb_t r;
        r.rob_id    = 6'(rob);
        r.wdata     = 32'h1000 + 32'(rob);
        r.exc_valid = 1'b0;
        r.exc_code  = 5'd0;
        return r;
    endfunction

    function automatic pipeline_cdb_t rnd_item();
        pipeline_cdb_t r;
        r.rob_id    = 6'($urandom);
        r.wdata     = $urandom;
        r.exc_valid = 1'($urandom);
        r.exc_code  = 5'($urandom);
        return r;
    endfunction

    task automatic drive();
        for (int s = 0; s < NS; s++) begin
            if (!(fu_valid[s] && !acc[s])) begin
                if (src_q[s].size() > 0) begin
                    fu_payload[s] = src_q[s].pop_front();
                    fu_valid[s]   = 1'b1;
                end else begin
                    fu_valid[s] = 1'b0;
                end
            end
        end
    endtask

    task automatic model_update();
        int lane;
        for (int s = 0; s < NS; s++) acc[s] = fu_valid[s] && (pend[s].size() == 0);
        if (!rst_n || flush) begin
            for (int s = 0; s < NS; s++) pend[s].delete();
            exp_valid = 2'b00;
            if (!rst_n) begin
                exp_pay[0] = '0;
                exp_pay[1] = '0;
            end
        end else begin
            for (int s = 0; s < NS; s++) if (acc[s]) pend[s].push_back(fu_payload[s]);
            exp_valid = 2'b00;
            lane = 0;
            for (int s = 0; s < NS; s++) begin
                if (pend[s].size() > 0 && lane < 2) begin
                    exp_pay[lane]   = pend[s].pop_front();
                    exp_valid[lane] = 1'b1;
                    lane++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [NS-1:0] exp_ready;
        for (int s = 0; s < NS; s++) exp_ready[s] = (pend[s].size() == 0);
        chk("cdb_valid", 64'(cdb_valid), 64'(exp_valid));
        chk("lane0_payload", 64'(cdb_payload[0]), 64'(exp_pay[0]));
        chk("lane1_payload", 64'(cdb_payload[1]), 64'(exp_pay[1]));
        chk("fu_ready", 64'(fu_ready), 64'(exp_ready));
    endtask

    task automatic cycle();
        drive();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet;
        int seq_rob[$];
        int seq_lane[$];

        exp_pay[0] = '0;
        exp_pay[1] = '0;
        @(negedge clk);

        // Reset then idle
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("idle_valid", 64'(cdb_valid), 64'h0);
            chk("idle_ready", 64'(fu_ready), 64'h3F);
        end

        // Priority among three concurrent sources
        src_q[0].push_back(mk_item(5));
        src_q[2].push_back(mk_item(9));
        src_q[4].push_back(mk_item(12));
        cycle();
        chk("prio_t1_valid", 64'(cdb_valid), 64'h3);
        chk("prio_t1_lane0", 64'(cdb_payload[0].rob_id), 64'd5);
        chk("prio_t1_lane1", 64'(cdb_payload[1].rob_id), 64'd9);
        chk("prio_t1_ready4", 64'(fu_ready[4]), 64'd0);
        cycle();
        chk("prio_t2_valid", 64'(cdb_valid), 64'h1);
        chk("prio_t2_lane0", 64'(cdb_payload[0].rob_id), 64'd12);
        idle(3);

        // Single source streaming at full rate
        for (int i = 0; i < 8; i++) src_q[3].push_back(mk_item(i));
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("stream_valid", 64'(cdb_valid), 64'h1);
            chk("stream_rob", 64'(cdb_payload[0].rob_id), 64'(i));
            chk("stream_ready3", 64'(fu_ready[3]), 64'd1);
        end
        idle(3);

        // Skid on src5 while src0/src1 hog both lanes
        for (int i = 0; i < 4; i++) begin
            src_q[0].push_back(mk_item(40 + i));
            src_q[1].push_back(mk_item(50 + i));
        end
        src_q[5].push_back(mk_item(1));
        src_q[5].push_back(mk_item(2));
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (i == 1) chk("skid_ready5_stall", 64'(fu_ready[5]), 64'd0);
            for (int k = 0; k < 2; k++) begin
                if (cdb_valid[k] && (cdb_payload[k].rob_id == 6'd1 || cdb_payload[k].rob_id == 6'd2)) begin
                    seq_rob.push_back(int'(cdb_payload[k].rob_id));
                    seq_lane.push_back(k);
                end
            end
        end
        chk("skid_count", 64'(seq_rob.size()), 64'd2);
        if (seq_rob.size() == 2) begin
            chk("skid_first", 64'(seq_rob[0]), 64'd1);
            chk("skid_second", 64'(seq_rob[1]), 64'd2);
            chk("skid_lane_a", 64'(seq_lane[0]), 64'd0);
            chk("skid_lane_b", 64'(seq_lane[1]), 64'd0);
        end

        // Flush with two buffered entries and a new input in the flush cycle
        src_q[0].push_back(mk_item(20));
        src_q[1].push_back(mk_item(21));
        src_q[4].push_back(mk_item(24));
        src_q[5].push_back(mk_item(25));
        cycle();
        chk("flush_setup_ready", 64'(fu_ready), 64'h0F);
        src_q[0].push_back(mk_item(33));
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_valid", 64'(cdb_valid), 64'h0);
        chk("flush_ready", 64'(fu_ready), 64'h3F);
        quiet = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (cdb_valid != 2'b00) quiet++;
        end
        chk("flush_no_stale", 64'(quiet), 64'd0);

        // Reset while two sources are buffered
        src_q[2].push_back(mk_item(60));
        src_q[3].push_back(mk_item(61));
        src_q[4].push_back(mk_item(62));
        src_q[5].push_back(mk_item(63));
        cycle();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        chk("rst_valid", 64'(cdb_valid), 64'h0);
        chk("rst_lane0", 64'(cdb_payload[0]), 64'h0);
        chk("rst_lane1", 64'(cdb_payload[1]), 64'h0);
        chk("rst_ready", 64'(fu_ready), 64'h3F);
        quiet = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (cdb_valid != 2'b00) quiet++;
        end
        chk("rst_no_stale", 64'(quiet), 64'd0);

        // Randomized traffic with occasional flush and reset
        for (int ph = 0; ph < 4; ph++) begin
            int rate [NS];
            for (int s = 0; s < NS; s++) rate[s] = int'($urandom_range(10, 90));
            for (int c = 0; c < 500; c++) begin
                for (int s = 0; s < NS; s++) begin
                    if (src_q[s].size() < 2 && int'($urandom_range(0, 99)) < rate[s])
                        src_q[s].push_back(rnd_item());
                end
                flush = ($urandom_range(0, 63) == 0);
                rst_n = !($urandom_range(0, 499) == 0);
                cycle();
            end
        end
        flush = 1'b0;
        rst_n = 1'b1;
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
